// File: rtl/rom_sdram_loader_if.sv
// rom_sdram_loader_if
//
// Purpose: byte-write channel between the ROM loader and one SDRAM
// controller port.
//
// Handshake: the master raises sd_wr with sd_addr/sd_din already valid and
// holds all three steady. The controller raises sd_busy while it services the
// write and drops it when the byte has been stored. The master then drops
// sd_wr and keeps it low for at least one cycle, so every request is a fresh
// rising edge.
//
// Signals:
//   sd_addr  master->slave  25  byte address
//   sd_din   master->slave   8  write byte
//   sd_wr    master->slave   1  level write request (rising edge = new write)
//   sd_busy  slave->master   1  controller is servicing the request
interface rom_sdram_loader_if;
    logic [24:0] sd_addr;
    logic [7:0]  sd_din;
    logic        sd_wr;
    logic        sd_busy;

    modport master (output sd_addr, output sd_din, output sd_wr, input sd_busy);
    modport slave  (input sd_addr, input sd_din, input sd_wr, output sd_busy);
endinterface

// File: rtl/rom_sdram_loader.sv
// rom_sdram_loader
//
// Purpose: takes the byte stream of a ROM download (ioctl_*), buffers it in a
// small FIFO and writes each byte to SDRAM through one controller channel,
// one request/acknowledge handshake per byte.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   ioctl_download   high while a download is in progress
//   ioctl_wr         one-cycle strobe: ioctl_addr/ioctl_dout hold a byte
//   ioctl_addr       byte address of the download byte (25 bits)
//   ioctl_dout       download byte
//   ioctl_wait       registered backpressure (occupancy >= WAIT_LEVEL)
//   sd               controller channel (rom_sdram_loader_if.master)
//   done             download finished and every byte written
//   overflow         sticky: a byte was dropped on a full FIFO
//   checksum         16-bit wrapping sum of accepted bytes
//
// Configuration: define LOADER_CHECKSUM_EN to build the checksum adder;
// otherwise checksum is tied to zero.
module rom_sdram_loader #(
    parameter logic [24:0] BASE_ADDR  = 25'h0000000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          WAIT_LEVEL = FIFO_DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ioctl_download,
    input  logic                      ioctl_wr,
    input  logic [24:0]               ioctl_addr,
    input  logic [7:0]                ioctl_dout,
    output logic                      ioctl_wait,
    rom_sdram_loader_if.master        sd,
    output logic                      done,
    output logic                      overflow,
    output logic [15:0]               checksum
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] WAIT_C  = (AW + 1)'(WAIT_LEVEL);

    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_ACK, ST_DONE, ST_GAP} state_t;

    state_t          state_q, state_d;
    logic [32:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count, count_next;
    logic            full, empty, accept, drop, pop;
    logic            dl_q, dl_rise;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign accept     = ioctl_wr & ioctl_download & ~full;
    assign drop       = ioctl_wr & ioctl_download & full;
    assign pop        = (state_q == ST_IDLE) & ~empty;
    assign dl_rise    = ioctl_download & ~dl_q;
    assign count_next = count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};

    // Storage carries no reset: clearing the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {ioctl_addr + BASE_ADDR, ioctl_dout};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!empty)      state_d = ST_REQ;
            ST_REQ:  if (sd.sd_busy)  state_d = ST_ACK;
            ST_ACK:  if (!sd.sd_busy) state_d = ST_DONE;
            ST_DONE:                  state_d = ST_GAP;
            ST_GAP:                   state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sd.sd_wr   <= 1'b0;
            sd.sd_addr <= '0;
            sd.sd_din  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            // sd_wr follows the next state so it rises on the same edge that
            // loads the address/data and falls on entry to DONE.
            sd.sd_wr <= (state_d == ST_REQ) || (state_d == ST_ACK);
            if (pop) begin
                {sd.sd_addr, sd.sd_din} <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            count      <= count_next;
            ioctl_wait <= (count_next >= WAIT_C);
            dl_q       <= ioctl_download;
            // A drop on the very cycle a new download starts is still reported.
            if (drop)         overflow <= 1'b1;
            else if (dl_rise) overflow <= 1'b0;
            if (dl_rise)
                done <= 1'b0;
            else if (!ioctl_download && empty && state_q == ST_IDLE)
                done <= 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum_q;
    always_ff @(posedge clk) begin
        if (reset)
            sum_q <= '0;
        else if (dl_rise)
            sum_q <= accept ? {8'h00, ioctl_dout} : 16'h0000;
        else if (accept)
            sum_q <= sum_q + {8'h00, ioctl_dout};
    end
    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_sdram_loader.sv
// tb_rom_sdram_loader
//
// Purpose: directed bench for rom_sdram_loader with BASE_ADDR=0x100000.
// A reference model (queue of expected writes, occupancy as accepted bytes
// minus started writes, handshake rules) is stepped once per cycle on the
// falling edge and compared with the DUT; scenario code adds literal checks.
// A small controller emulation answers sd_wr with configurable latency.
module tb_rom_sdram_loader;
    localparam logic [24:0] BASE   = 25'h100000;
    localparam int          DEPTH  = 8;
    localparam int          WLEVEL = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait, done, overflow;
    logic [15:0] checksum;

    rom_sdram_loader_if bus ();

    rom_sdram_loader #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .WAIT_LEVEL(WLEVEL)) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .sd             (bus.master),
        .done           (done),
        .overflow       (overflow),
        .checksum       (checksum)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- controller emulation ----------------
    int   c_lat = 0, c_len = 2;
    logic c_never = 1'b0;
    int   c_ph = 0, c_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            bus.sd_busy = 1'b0;
            c_ph = 0;
            c_cnt = 0;
        end else begin
            case (c_ph)
                0: if (bus.sd_wr && !c_never) begin c_ph = 1; c_cnt = 0; end
                1: if (c_cnt >= c_lat) begin bus.sd_busy = 1'b1; c_cnt = 0; c_ph = 2; end
                   else c_cnt++;
                2: if (c_cnt >= c_len - 1) begin bus.sd_busy = 1'b0; c_ph = 3; end
                   else c_cnt++;
                default: if (!bus.sd_wr) c_ph = 0;
            endcase
        end
    end

    // ---------------- input snapshot at the active edge ----------------
    logic        s_reset, s_dl, s_wr, s_busy;
    logic [24:0] s_addr;
    logic [7:0]  s_dout;

    always @(posedge clk) begin
        s_reset = reset;
        s_dl    = ioctl_download;
        s_wr    = ioctl_wr;
        s_busy  = bus.sd_busy;
        s_addr  = ioctl_addr;
        s_dout  = ioctl_dout;
    end

    // ---------------- scoreboard / model ----------------
    int n_tests = 0, n_fail = 0;

    logic [32:0] exp_q[$];
    logic [24:0] log_addr[$];
    logic [7:0]  log_din[$];
    int          m_occ = 0, m_low = 100, hi_run = 0, hi_max = 0, n_rise = 0;
    logic        m_ovf = 1'b0, m_dl_prev = 1'b0, m_wr_prev = 1'b0, m_seen = 1'b0;
    logic        wait_seen = 1'b0;
    logic [15:0] m_sum = '0;
    logic [24:0] m_addr = '0;
    logic [7:0]  m_din = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic        pop, accept, dl_rise, full;
        logic [32:0] e;
        if (s_reset) begin
            exp_q.delete();
            m_occ = 0; m_ovf = 1'b0; m_sum = '0; m_dl_prev = 1'b0;
            m_seen = 1'b0; m_low = 100; hi_run = 0;
            chk("reset_sd_wr", bus.sd_wr, 0);
            chk("reset_sd_addr", bus.sd_addr, 0);
            chk("reset_sd_din", bus.sd_din, 0);
            chk("reset_wait", ioctl_wait, 0);
            chk("reset_done", done, 0);
            chk("reset_overflow", overflow, 0);
            chk("reset_checksum", checksum, 0);
        end else begin
            dl_rise   = s_dl && !m_dl_prev;
            m_dl_prev = s_dl;
            if (dl_rise) begin m_ovf = 1'b0; m_sum = '0; end
            // Request must persist until busy has been seen high and then low.
            if (m_wr_prev) begin
                chk("sd_wr_hold", bus.sd_wr, (m_seen && !s_busy) ? 0 : 1);
                if (bus.sd_wr) begin
                    chk("addr_stable", bus.sd_addr, m_addr);
                    chk("din_stable", bus.sd_din, m_din);
                end
            end
            pop = bus.sd_wr && !m_wr_prev;
            if (pop) begin
                n_rise++;
                chk("low_phase_before_write", (m_low >= 3) ? 1 : 0, 1);
                chk("write_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("write_addr", bus.sd_addr, e[32:8]);
                    chk("write_din", bus.sd_din, e[7:0]);
                end
                m_addr = bus.sd_addr;
                m_din  = bus.sd_din;
                log_addr.push_back(bus.sd_addr);
                log_din.push_back(bus.sd_din);
                m_seen = 1'b0;
            end else if (m_wr_prev && bus.sd_wr && s_busy) begin
                m_seen = 1'b1;
            end
            m_low  = bus.sd_wr ? 0 : m_low + 1;
            hi_run = bus.sd_wr ? hi_run + 1 : 0;
            if (hi_run > hi_max) hi_max = hi_run;
            full   = (m_occ >= DEPTH);
            accept = s_wr && s_dl && !full;
            if (s_wr && s_dl && full) m_ovf = 1'b1;
            if (accept) begin
                exp_q.push_back({s_addr + BASE, s_dout});
                m_sum += {8'h00, s_dout};
            end
            m_occ = m_occ + (accept ? 1 : 0) - (pop ? 1 : 0);
            chk("ioctl_wait", ioctl_wait, (m_occ >= WLEVEL) ? 1 : 0);
            chk("overflow", overflow, m_ovf);
`ifdef LOADER_CHECKSUM_EN
            chk("checksum", checksum, m_sum);
`else
            chk("checksum", checksum, 0);
`endif
            if (ioctl_wait) wait_seen = 1'b1;
        end
        m_wr_prev = bus.sd_wr;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        model_step();
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        for (int i = 0; i < max && !done; i++) tick();
        chk(name, done, 1);
    endtask

    // ---------------- scenarios ----------------
    int r0;

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_lit_sd_wr", bus.sd_wr, 0);
        chk("rst_lit_done", done, 0);
        chk("rst_lit_checksum", checksum, 16'h0000);
        reset = 1'b0;
        tick();

        // Single byte
        c_lat = 1; c_len = 2; c_never = 1'b0;
        ioctl_download = 1'b1;
        tick();
        chk("done_clear_on_rise", done, 0);
        log_addr.delete(); log_din.delete();
        r0 = n_rise;
        strobe(25'h10, 8'hA5);
        ioctl_download = 1'b0;
        wait_done(200, "single_done");
        chk("single_count", n_rise - r0, 1);
        chk("single_addr", log_addr.size() > 0 ? log_addr[0] : 25'h0, 25'h100010);
        chk("single_din", log_din.size() > 0 ? log_din[0] : 8'h0, 8'hA5);

        // Burst of 8 with a 10-cycle busy per write
        c_lat = 0; c_len = 10;
        ioctl_download = 1'b1;
        tick();
        log_addr.delete(); log_din.delete();
        wait_seen = 1'b0;
        r0 = n_rise;
        for (int i = 0; i < 8; i++) strobe(25'(i), 8'h30 + 8'(i));
        ioctl_download = 1'b0;
        wait_done(2000, "burst_done");
        chk("burst_wait_seen", wait_seen, 1);
        chk("burst_no_overflow", overflow, 0);
        chk("burst_wait_low_after", ioctl_wait, 0);
        chk("burst_count", n_rise - r0, 8);
        for (int i = 0; i < 8; i++) begin
            chk("burst_addr", log_addr.size() > i ? log_addr[i] : 25'h0, 25'h100000 + 25'(i));
            chk("burst_din", log_din.size() > i ? log_din[i] : 8'h0, 8'h30 + 8'(i));
        end

        // Overflow: controller never answers
        c_never = 1'b1;
        ioctl_download = 1'b1;
        tick();
        r0 = n_rise;
        for (int i = 0; i < 10; i++) strobe(25'h200 + 25'(i), 8'(i));
        tick();
        chk("ovf_flag", overflow, 1);
        chk("ovf_wait", ioctl_wait, 1);
        chk("ovf_model_occ", m_occ, 8);
        chk("ovf_one_write_started", n_rise - r0, 1);
        chk("ovf_sd_wr_held", bus.sd_wr, 1);
        reset = 1'b1;
        tick();
        chk("ovf_rst_sd_wr", bus.sd_wr, 0);
        chk("ovf_rst_overflow", overflow, 0);
        chk("ovf_rst_wait", ioctl_wait, 0);
        reset = 1'b0;
        c_never = 1'b0;
        r0 = n_rise;
        repeat (20) tick();
        chk("ovf_queue_discarded", n_rise - r0, 0);
        chk("ovf_done_low_in_download", done, 0);

        // Delayed acknowledge: busy stays low 50 cycles after sd_wr
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        tick();
        c_lat = 50; c_len = 2;
        hi_max = 0;
        log_addr.delete(); log_din.delete();
        r0 = n_rise;
        strobe(25'h20, 8'h5A);
        ioctl_download = 1'b0;
        wait_done(500, "delayed_done");
        chk("delayed_count", n_rise - r0, 1);
        chk("delayed_hold_long", (hi_max >= 51) ? 1 : 0, 1);
        chk("delayed_addr", log_addr.size() > 0 ? log_addr[0] : 25'h0, 25'h100020);

        // Reset while the FSM is in ACK, with a second byte queued
        ioctl_download = 1'b1;
        tick();
        c_lat = 0; c_len = 30;
        strobe(25'h30, 8'h77);
        strobe(25'h31, 8'h78);
        for (int i = 0; i < 50 && !bus.sd_busy; i++) tick();
        chk("mid_busy_seen", bus.sd_busy, 1);
        repeat (3) tick();
        chk("mid_sd_wr_before_reset", bus.sd_wr, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_sd_wr", bus.sd_wr, 0);
        chk("mid_rst_done", done, 0);
        reset = 1'b0;
        r0 = n_rise;
        repeat (25) tick();
        chk("mid_no_more_writes", n_rise - r0, 0);
        chk("mid_sd_wr_low", bus.sd_wr, 0);
        chk("mid_done_low", done, 0);

        // Checksum: 0xFF + 0xFF + 0x03
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        tick();
        c_lat = 0; c_len = 2;
        r0 = n_rise;
        strobe(25'h40, 8'hFF);
        strobe(25'h41, 8'hFF);
        strobe(25'h42, 8'h03);
        tick();
`ifdef LOADER_CHECKSUM_EN
        chk("checksum_lit", checksum, 16'h0201);
`else
        chk("checksum_lit", checksum, 16'h0000);
`endif
        ioctl_download = 1'b0;
        wait_done(300, "checksum_done");
        chk("checksum_count", n_rise - r0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_sdram_loader.md
ROM_SDRAM_LOADER -- requirements
Module: rom_sdram_loader

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- BASE_ADDR, 25'h0000000, byte offset added to ioctl_addr to form sd_addr.
- FIFO_DEPTH, 8, write-buffer entries; power of two, 4..32.
- WAIT_LEVEL, FIFO_DEPTH-2, occupancy at or above which ioctl_wait asserts.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, system clock; same clock as the SDRAM controller.
- reset, in, 1, synchronous, active-high.
- ioctl_download, in, 1, high for the duration of a ROM download.
- ioctl_wr, in, 1, single-cycle strobe: byte valid on ioctl_addr/ioctl_dout.
- ioctl_addr, in, 25, byte address of the download byte.
- ioctl_dout, in, 8, download byte.
- ioctl_wait, out, 1, backpressure to the download source.
- sd_addr, out, 25, byte address to the controller channel.
- sd_din, out, 8, write byte to the controller channel.
- sd_wr, out, 1, level write request; the controller acts on its rising edge.
- sd_busy, in, 1, channel busy from the controller.
- done, out, 1, download finished and all bytes written.
- overflow, out, 1, sticky: a byte was dropped because the FIFO was full.
- checksum, out, 16, running byte sum (see Configuration).

Function
REQ-003 Each ioctl_wr with ioctl_download=1 and FIFO not full SHALL push {ioctl_addr+BASE_ADDR (mod 2^25), ioctl_dout}. ioctl_wr with ioctl_download=0 SHALL be ignored.
REQ-004 ioctl_wr on a full FIFO SHALL drop the byte and set overflow; overflow clears only on reset or on the rising edge of ioctl_download.
REQ-005 ioctl_wait SHALL be registered and equal (occupancy >= WAIT_LEVEL), evaluated after the current push/pop.
REQ-006 Write FSM states: IDLE, REQ, ACK, DONE, GAP.
REQ-007 IDLE: if FIFO not empty, pop the head into sd_addr/sd_din and go to REQ, setting sd_wr=1 on the same edge.
REQ-008 REQ: hold sd_wr=1; on sd_busy=1 go to ACK. No timeout: another channel may delay service indefinitely.
REQ-009 ACK: hold sd_wr=1; on sd_busy=0 go to DONE.
REQ-010 DONE: set sd_wr=0, go to GAP.
REQ-011 GAP: sd_wr=0 for exactly one cycle, then go to IDLE. This guarantees a low phase so the next request is a new rising edge.
REQ-012 sd_addr/sd_din SHALL stay stable from REQ entry until the return to IDLE.
REQ-013 Push and pop in the same cycle SHALL leave occupancy unchanged; the read and write pointers wrap modulo FIFO_DEPTH.
REQ-014 done SHALL clear on the rising edge of ioctl_download and SHALL set one cycle after all of the following hold: ioctl_download=0, FIFO empty, FSM in IDLE.
REQ-015 A falling edge of ioctl_download with bytes still queued SHALL still drain the FIFO fully before done sets.
REQ-016 Minimum byte throughput: one byte per (controller service latency + 3) cycles.

Reset
REQ-017 On reset=1 at a clock edge, outputs SHALL be: sd_wr=0, sd_addr=0, sd_din=0, ioctl_wait=0, done=0, overflow=0, checksum=0.
REQ-018 On reset, FSM SHALL go to IDLE, pointers and occupancy SHALL clear, and queued bytes SHALL be discarded. This holds even mid-handshake; sd_wr drops on the same edge.

Configuration
REQ-019 Macro LOADER_CHECKSUM_EN.
- Defined: checksum is the 16-bit wrapping sum of every byte accepted into the FIFO. It clears on the rising edge of ioctl_download.
- Undefined: checksum is tied to 16'h0000 and no adder is synthesized.

Verification
REQ-020 Directed scenarios:
- Single byte: download=1, wr addr 0x10 data 0xA5, BASE_ADDR=0x100000 -> one sd_wr rising edge with sd_addr=0x100010, sd_din=0xA5; done=1 after download falls.
- Burst: 8 back-to-back strobes, controller busy 10 cycles per write -> ioctl_wait high once occupancy reaches 6, no overflow, 8 writes issued in order.
- Overflow: 10 back-to-back strobes with wait ignored and sd_busy never rising -> overflow=1, exactly 8 bytes queued.
- Delayed ack: sd_busy held low 50 cycles after sd_wr -> sd_wr stays high and sd_addr is stable; exactly one write completes.
- Reset mid-handshake (FSM in ACK) -> sd_wr=0 next edge, FIFO empty, done=0, no further sd_wr edges.
- LOADER_CHECKSUM_EN: bytes 0xFF,0xFF,0x03 -> checksum=0x0201; with macro undefined -> checksum=0x0000.
